// File: rtl/load_store_unit.sv
// load_store_unit -- memory stage of the RV32I core.
//
// Runs a single req/ack transaction on the data-memory port for each load or
// store presented by decode. It steers byte lanes, generates byte enables,
// sign/zero-extends load data, and aborts an access that waits too long.
//
// Parameters:
//   MAX_WAIT      cycles spent in REQ without dm_ack before the access aborts
//                 with fault (1..65535)
// Optional build macro:
//   MISALIGN_TRAP_EN  when defined, misaligned half/word accesses raise fault
//                     without touching the bus; when undefined, the offending
//                     low address bits are ignored
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_read, mem_write              access request from decode (write wins)
//   mem_size, mem_unsigned           00 byte, 01 half, 1x word; zero-extend
//   addr, wdata                      byte address, store data
//   stall                            holds upstream stages during the access
//   rdata, rdata_valid, fault        load result / completion pulses in DONE
//   dm_req, dm_we, dm_addr, dm_be,
//   dm_wdata                         registered data-memory request
//   dm_ack, dm_rdata                 data-memory response
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [16:0] MAX_WAIT_W = 17'(MAX_WAIT);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        is_load_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [3:0]  dm_be_q;
  logic [31:0] dm_wdata_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        fault_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] byte_lane;
  logic [31:0] half_lane;
  logic [31:0] load_ext;
  logic [16:0] cnt_next;

  assign cnt_next = {1'b0, cnt_q} + 17'd1;

  // Byte enables and lane-replicated store data from the live decode inputs.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    case (mem_size)
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  // Load extract from the word returned on the bus; half loads use addr[1] only.
  always_comb begin
    byte_lane = dm_rdata >> {off_q, 3'b000};
    half_lane = dm_rdata >> {off_q[1], 4'b0000};
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & byte_lane[7]}}, byte_lane[7:0]};
      2'b01:   load_ext = {{16{~uns_q & half_lane[15]}}, half_lane[15:0]};
      default: load_ext = dm_rdata;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((mem_size == 2'b01) && addr[0]) ||
                    (mem_size[1] && (addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      is_load_q     <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      off_q         <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_be_q       <= '0;
      dm_wdata_q    <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses visible only in DONE.
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            is_load_q <= ~mem_write;
            size_q    <= mem_size;
            uns_q     <= mem_unsigned;
            off_q     <= addr[1:0];
`ifdef MISALIGN_TRAP_EN
            if (misalign) begin
              state_q <= S_DONE;
              fault_q <= 1'b1;
            end else
`endif
            begin
              state_q    <= S_REQ;
              cnt_q      <= '0;
              dm_req_q   <= 1'b1;
              dm_we_q    <= mem_write;
              dm_addr_q  <= {addr[31:2], 2'b00};
              dm_be_q    <= be_d;
              dm_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          // An ack in the final permitted cycle still completes the access.
          if (dm_ack) begin
            state_q       <= S_DONE;
            dm_req_q      <= 1'b0;
            dm_we_q       <= 1'b0;
            rdata_valid_q <= is_load_q;
            rdata_q       <= is_load_q ? load_ext : '0;
          end else if (cnt_next == MAX_WAIT_W) begin
            state_q  <= S_DONE;
            dm_req_q <= 1'b0;
            dm_we_q  <= 1'b0;
            fault_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_next[15:0];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall = ~rst & (((state_q == S_IDLE) & (mem_read | mem_write)) |
                         (state_q == S_REQ));

  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_be       = dm_be_q;
  assign dm_wdata    = dm_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed table of access records, a few
// multi-cycle sequences (reset, reset mid-access) and randomized accesses
// checked against a byte-arithmetic reference model.
module tb_load_store_unit;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, fault;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .fault(fault),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a, wd, word;
    int unsigned dly;     // REQ cycles without ack before ack is given
    logic [3:0]  be;
    logic [31:0] dwd, rdata;
    logic        valid, fault;
    int unsigned stall_cyc;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] word, input int unsigned dly,
                              input logic [3:0] be, input logic [31:0] dwd,
                              input logic [31:0] rda, input logic valid, input logic flt,
                              input int unsigned sc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd; v.word = word;
    v.dly = dly; v.be = be; v.dwd = dwd; v.rdata = rda; v.valid = valid; v.fault = flt;
    v.stall_cyc = sc;
    return v;
  endfunction

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int unsigned m_nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int unsigned m_off(input logic [1:0] sz, input logic [31:0] a);
    int unsigned lo = a % 4;
    return (sz == 2'd0) ? lo : (sz == 2'd1) ? (lo / 2) * 2 : 0;
  endfunction

  function automatic vec_t model(input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] word, input int unsigned dly);
    vec_t v;
    int unsigned n = m_nbytes(sz);
    int unsigned off = m_off(sz, a);
    logic [31:0] bev, mask, val;
    logic mis;
    v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.a = a; v.wd = wd; v.word = word; v.dly = dly;
    bev = ((32'd1 << n) - 32'd1) << off;
    v.be = bev[3:0];
    for (int i = 0; i < 4; i++) v.dwd[8*i +: 8] = wd[8*(i % n) +: 8];
`ifdef MISALIGN_TRAP_EN
    mis = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
`else
    mis = 1'b0;
`endif
    if (n == 4) val = word;
    else begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      val = (word >> (8 * off)) & mask;
      if (!uns && val[8*n-1]) val = val | ~mask;
    end
    if (mis) begin
      v.fault = 1'b1; v.valid = 1'b0; v.rdata = '0; v.stall_cyc = 1;
    end else begin
      v.fault = (dly >= MW);
      v.valid = !v.fault && !wr;
      v.rdata = v.valid ? val : 32'd0;
      v.stall_cyc = 1 + (v.fault ? MW : dly + 1);
    end
    return v;
  endfunction

  // ---------------- one complete access ----------------
  task automatic run(input vec_t v, input string tag);
    int unsigned n_req = 0;
    int unsigned n_stall = 0;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; mem_size = v.sz; mem_unsigned = v.uns;
    addr = v.a; wdata = v.wd;
    #1;
    if (stall) n_stall++;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    while (dm_req && n_req < 20) begin
      if (n_req == 0) begin
        chk({tag, ".dm_addr"}, dm_addr, v.a & 32'hFFFF_FFFC);
        chk({tag, ".dm_we"}, 32'(dm_we), 32'(v.wr));
        chk({tag, ".dm_be"}, 32'(dm_be), 32'(v.be));
        if (v.wr) chk({tag, ".dm_wdata"}, dm_wdata, v.dwd);
      end
      if (stall) n_stall++;
      dm_ack = (n_req == v.dly);
      dm_rdata = dm_ack ? v.word : $urandom;
      n_req++;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    chk({tag, ".req_released"}, 32'(dm_req), 32'd0);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".stall_cycles"}, n_stall, v.stall_cyc);
    chk({tag, ".req_cycles"}, n_req, v.stall_cyc - 1);
    chk({tag, ".fault"}, 32'(fault), 32'(v.fault));
    chk({tag, ".rdata_valid"}, 32'(rdata_valid), 32'(v.valid));
    if (v.valid || v.fault) chk({tag, ".rdata"}, rdata, v.rdata);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
    addr = '0; wdata = '0; dm_ack = 1'b0; dm_rdata = '0;

    // Reset state; stall stays low under reset even with a request present.
    @(negedge clk); @(negedge clk);
    mem_read = 1'b1; #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.dm_req", 32'(dm_req), 32'd0);
    chk("rst.dm_we", 32'(dm_we), 32'd0);
    chk("rst.dm_be", 32'(dm_be), 32'd0);
    chk("rst.dm_addr", dm_addr, 32'd0);
    chk("rst.dm_wdata", dm_wdata, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    @(negedge clk);
    mem_read = 1'b0; rst = 1'b0;

    // Directed table: rd wr sz uns addr wdata word dly | be dwd rdata valid fault stall
    tbl[0] = mk(1,0,2'd0,0,32'h1003,32'h0,32'h80FFFFFF,0, 4'b1000,32'h0,32'hFFFFFF80,1,0,2);
    tbl[1] = mk(1,0,2'd1,1,32'h1002,32'h0,32'hBEEF1234,0, 4'b1100,32'h0,32'h0000BEEF,1,0,2);
    tbl[2] = mk(0,1,2'd0,0,32'h2001,32'hAB,32'h0,3,       4'b0010,32'hABABABAB,32'h0,0,0,5);
    tbl[3] = mk(1,0,2'd2,0,32'h4000,32'h0,32'h0,100,      4'b1111,32'h0,32'h0,0,1,5);
`ifdef MISALIGN_TRAP_EN
    tbl[4] = mk(1,0,2'd2,0,32'h3002,32'h0,32'h12345678,0, 4'b1111,32'h0,32'h0,0,1,1);
`else
    tbl[4] = mk(1,0,2'd2,0,32'h3002,32'h0,32'h12345678,0, 4'b1111,32'h0,32'h12345678,1,0,2);
`endif
    tbl[5] = mk(1,1,2'd1,0,32'h5002,32'h0000CAFE,32'hFFFFFFFF,1, 4'b1100,32'hCAFECAFE,32'h0,0,0,3);
    tbl[6] = mk(1,0,2'd1,0,32'h6000,32'h0,32'h00008001,2, 4'b0011,32'h0,32'hFFFF8001,1,0,4);
    tbl[7] = mk(1,0,2'd0,1,32'h7001,32'h0,32'h0000F700,0, 4'b0010,32'h0,32'h000000F7,1,0,2);
    tbl[8] = mk(0,1,2'd2,0,32'h8004,32'h12345678,32'h0,4, 4'b1111,32'h12345678,32'h0,0,1,5);
    tbl[9] = mk(1,0,2'd3,0,32'h9008,32'h0,32'hA5A55A5A,3, 4'b1111,32'h0,32'hA5A55A5A,1,0,5);
    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting in REQ, followed by a late ack.
    @(negedge clk);
    mem_read = 1'b1; mem_size = 2'd2; addr = 32'h0000_A000;
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    chk("rstreq.dm_req_before", 32'(dm_req), 32'd1);
    rst = 1'b1; #1;
    chk("rstreq.stall_in_rst", 32'(stall), 32'd0);
    @(negedge clk);
    chk("rstreq.dm_req_after", 32'(dm_req), 32'd0);
    rst = 1'b0; dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstreq.late_valid", 32'(rdata_valid), 32'd0);
      chk("rstreq.late_fault", 32'(fault), 32'd0);
      chk("rstreq.late_req", 32'(dm_req), 32'd0);
    end
    dm_ack = 1'b0;

    // Randomized accesses against the model.
    for (int i = 0; i < 80; i++) begin
      logic r, w;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      rv = model(r, w, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                 $urandom_range(0, 6));
      run(rv, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
